// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, forward/inverse S-box tables and SubBytes FSM state type
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational inverse AES S-box lookup, used only by the SUB_BYTES_SELFCHECK_EN build
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] byte_in,
  output logic [AES_BYTE_W-1:0] byte_out
);

  assign byte_out = INV_SBOX[byte_in];

endmodule

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup, one byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] byte_in,
  output logic [AES_BYTE_W-1:0] byte_out
);

  assign byte_out = SBOX[byte_in];

endmodule

// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - iterative AES SubBytes, BYTES_PER_CYCLE shared S-boxes per pass
// Optional inverse-S-box self-check with sticky check_err when SUB_BYTES_SELFCHECK_EN is defined.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] state_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] state_out
`ifdef SUB_BYTES_SELFCHECK_EN
  ,
  output logic                   check_err
`endif
);

  localparam int NB = 16 / BYTES_PER_CYCLE;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = BYTES_PER_CYCLE * AES_BYTE_W;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [AES_BLOCK_W-1:0] data_q;
  logic [AES_BLOCK_W-1:0] next_data;
  logic [LW-1:0]          lane_in;
  logic [LW-1:0]          lane_out;
  logic                   accept;

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Chunk select by constant slices keeps every index in range for all legal NB.
  always_comb begin
    lane_in = '0;
    for (int c = 0; c < NB; c++) begin
      if (int'(cnt) == c) lane_in = data_q[c*LW +: LW];
    end
  end

  always_comb begin
    next_data = data_q;
    for (int c = 0; c < NB; c++) begin
      if (int'(cnt) == c) next_data[c*LW +: LW] = lane_out;
    end
  end

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    aes_sbox u_sbox (
      .byte_in  (lane_in[l*AES_BYTE_W +: AES_BYTE_W]),
      .byte_out (lane_out[l*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      out_valid <= 1'b0;
      state_out <= '0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            data_q   <= state_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          data_q <= next_data;
          if (int'(cnt) == NB - 1) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state_out <= next_data;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUB_BYTES_SELFCHECK_EN
  logic [LW-1:0] inv_out;
  logic          mismatch;

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_chk
    aes_inv_sbox u_inv (
      .byte_in  (lane_out[l*AES_BYTE_W +: AES_BYTE_W]),
      .byte_out (inv_out[l*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  assign mismatch = (state == BUSY) && (inv_out != lane_in);

  // Sticky until the next block is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_err <= 1'b0;
    end else if (accept) begin
      check_err <= 1'b0;
    end else if (mismatch) begin
      check_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - five engines (BPC 1,2,4,8,16) against a GF(2^8) arithmetic S-box model
module tb_sub_bytes_engine;

  localparam int NDUT = 5;
  localparam int MAIN = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] state_in = '0;
  logic         in_ready  [NDUT];
  logic         out_valid [NDUT];
  logic [127:0] state_out [NDUT];
`ifdef SUB_BYTES_SELFCHECK_EN
  logic         check_err [NDUT];
`endif

  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  int           lat [NDUT];
  logic [127:0] got [NDUT];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    sub_bytes_engine #(.BYTES_PER_CYCLE(1 << k)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[k]),
      .state_in  (state_in),
      .out_valid (out_valid[k]),
      .out_ready (out_ready),
      .state_out (state_out[k])
`ifdef SUB_BYTES_SELFCHECK_EN
      ,
      .check_err (check_err[k])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Multiplicative inverse as x^254, then the AES affine transform.
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic all_ready();
    logic r = 1'b1;
    for (int k = 0; k < NDUT; k++) r = r & in_ready[k];
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!all_ready() && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_ready"}, 128'(all_ready()), 128'd1);
  endtask

  task automatic run_block(input logic [127:0] d, input string tag);
    wait_ready(tag);
    @(negedge clk);
    state_in = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    state_in = rand128();
    for (int k = 0; k < NDUT; k++) begin
      lat[k] = -1;
      got[k] = '0;
      check_eq({tag, "_busy_not_ready"}, 128'(in_ready[k]), 128'd0);
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (out_valid[k] && lat[k] < 0) begin
          lat[k] = n;
          got[k] = state_out[k];
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("%s_lat_bpc%0d", tag, 1 << k), 128'(lat[k]), 128'(16 >> k));
      check_eq($sformatf("%s_data_bpc%0d", tag, 1 << k), got[k], sub_state(d));
      check_eq($sformatf("%s_roundtrip_bpc%0d", tag, 1 << k), inv_state(got[k]), d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int           seen;

    for (int v = 0; v < 256; v++) fwd_tab[v] = sbox_model(8'(v));
    for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check_eq("reset_out_valid", 128'(out_valid[k]), 128'd0);
      check_eq("reset_state_out", state_out[k], 128'd0);
      check_eq("reset_in_ready", 128'(in_ready[k]), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("release_in_ready_low", 128'(in_ready[MAIN]), 128'd0);
    @(posedge clk);
    #1;
    check_eq("release_in_ready_high", 128'(in_ready[MAIN]), 128'd1);

    run_block(128'h0, "zero");
    check_eq("zero_const", got[MAIN], {16{8'h63}});

    run_block(128'hffeeddccbbaa99887766554433221100, "vec");
    check_eq("vec_const", got[MAIN], 128'h1628c14beaaceec4f533fc1bc3938263);

    for (int i = 0; i < 8; i++) run_block(rand128(), $sformatf("rnd%0d", i));

    // Backpressure: every engine parks in DONE while out_ready is low.
    d = rand128();
    wait_ready("hold");
    @(negedge clk);
    out_ready = 1'b0;
    state_in = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) check_eq("hold_valid_up", 128'(out_valid[k]), 128'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      state_in = rand128();
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        check_eq("hold_valid", 128'(out_valid[k]), 128'd1);
        check_eq("hold_not_ready", 128'(in_ready[k]), 128'd0);
        check_eq("hold_data", state_out[k], sub_state(d));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    state_in = rand128();
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check_eq("release_valid_low", 128'(out_valid[k]), 128'd0);
      check_eq("release_idle_no_accept", 128'(in_ready[k]), 128'd1);
      check_eq("release_data_held", state_out[k], sub_state(d));
    end
    in_valid = 1'b0;

    // Reset in the second BUSY cycle of the BPC=4 engine.
    wait_ready("rst");
    @(negedge clk);
    state_in = rand128();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check_eq("rst_out_valid", 128'(out_valid[k]), 128'd0);
      check_eq("rst_state_out", state_out[k], 128'd0);
      check_eq("rst_in_ready", 128'(in_ready[k]), 128'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) if (out_valid[k]) seen++;
    end
    check_eq("rst_no_output", 128'(seen), 128'd0);
    run_block(rand128(), "post_rst");

`ifdef SUB_BYTES_SELFCHECK_EN
    check_eq("chk_clean", 128'(check_err[MAIN]), 128'd0);
    force g_dut[MAIN].dut.g_chk[0].u_inv.byte_out = 8'h5a;
    run_block(128'h0, "chk_fault");
    release g_dut[MAIN].dut.g_chk[0].u_inv.byte_out;
    repeat (3) @(posedge clk);
    #1;
    check_eq("chk_set_sticky", 128'(check_err[MAIN]), 128'd1);
    run_block(rand128(), "chk_clear");
    check_eq("chk_cleared", 128'(check_err[MAIN]), 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
